noc_pipeline_link: RTL and testbench
====================================

// Module: noc_pipeline_link
// PURPOSE
// - Credit-based router-to-router link inserted on each mesh port between a router output and the neighbouring router input.
// - Retimes the forward flit path and the reverse credit path by NUM_PIPELINE register stages each, for long-wire timing closure in the sweep.
// - Carries an in-line protocol monitor: shadow credit counter, packet framing tracker, flit/packet statistics, sticky error flags.
// PARAMETERS
// - FLIT_WIDTH    32  flit payload width
// - DEST_WIDTH    6   destination field width (TDEST + TID)
// - NUM_PIPELINE  0   register stages per direction, 0..8; 0 = combinational pass-through
// - CREDIT_DEPTH  1   downstream input buffer depth (equals FLIT_BUFFER_DEPTH), >=1
// - CNT_WIDTH     32  statistics counter width
// PORTS
// - clk          in   1           NoC clock; single clock domain
// - rst          in   1           synchronous, active-high reset
// - data_in      in   FLIT_WIDTH  flit from upstream router output
// - dest_in      in   DEST_WIDTH  destination of flit
// - is_tail_in   in   1           last flit of packet
// - send_in      in   1           flit valid, one flit per cycle
// - credit_out   out  1           credit returned to upstream router
// - data_out     out  FLIT_WIDTH  flit to downstream router input
// - dest_out     out  DEST_WIDTH  destination, delayed
// - is_tail_out  out  1           tail flag, delayed
// - send_out     out  1           flit valid, delayed
// - credit_in    in   1           credit from downstream router
// - stat_clear   in   1           synchronous clear of statistics counters
// - flit_count   out  CNT_WIDTH   flits delivered (send_out), saturating
// - packet_count out  CNT_WIDTH   tails delivered (send_out & is_tail_out), saturating
// - credit_avail out  $clog2(CREDIT_DEPTH+1)  shadow credit count seen by upstream
// - in_packet    out  1           head/body sent, tail not yet sent (upstream side)
// - err_underflow out 1           sticky: send_in while credit_avail==0
// - err_overflow out  1           sticky: credit_out while credit_avail==CREDIT_DEPTH
// BEHAVIOUR
// - Forward: {data,dest,is_tail,send} pass NUM_PIPELINE stages; latency exactly NUM_PIPELINE cycles, throughput 1 flit/cycle, no back-pressure.
// - Reverse: credit passes NUM_PIPELINE stages; latency NUM_PIPELINE cycles; one credit per cycle max.
// - Only send and credit bits are reset (to 0); data/dest/is_tail registers are not reset and are don't-care when send=0.
// - NUM_PIPELINE=0: outputs equal inputs in the same cycle; monitor still active.
// - Shadow credit: reset to CREDIT_DEPTH; -1 on send_in, +1 on credit_out, both same cycle = unchanged.
// - Underflow: send_in with count 0 -> err_underflow=1 next cycle, count holds 0 (unless credit_out same cycle: net 0, no error).
// - Overflow: credit_out with count CREDIT_DEPTH and no send_in -> err_overflow=1 next cycle, count holds.
// - Framing: in_packet set on send_in&~is_tail_in, cleared on send_in&is_tail_in; single-flit packet leaves it 0.
// - Counters: registered, visible the cycle after the send_out event; saturate at all-ones; stat_clear wins over increment (result 0).
// - Error flags cleared only by rst; stat_clear does not touch them or credit_avail.
// - Reset values: send_out=0, credit_out=0 (when NUM_PIPELINE>0), counters 0, credit_avail=CREDIT_DEPTH, in_packet=0, errors 0.
// - Reset mid-operation: all in-flight flits and credits in stages are discarded; system reset is global so both routers re-initialise consistently.
// STRUCTURE
// - Package noc_link_pkg: typedef flit_t {data, dest, is_tail}, MAX_PIPELINE=8 constant, sat_inc function.
// - Sub-module noc_link_stage: one forward register (flit_t + send) plus one credit register; generate NUM_PIPELINE instances in a chain.
// - Monitor logic (credit counter, framing, stats) lives in the top module.
// TESTING
// - NUM_PIPELINE=2: send_in=1, data_in=32'hA5A5_0001, dest_in=6'h05 at cycle 0 -> send_out=1 with same data/dest at cycle 2 only; credit_in at cycle 5 -> credit_out at cycle 7.
// - NUM_PIPELINE=0: toggle send_in/credit_in -> send_out/credit_out identical same cycle; flit_count increments next cycle.
// - CREDIT_DEPTH=1, no credits: send_in on cycles 0 and 1 -> credit_avail 0 at cycle 1, err_underflow=1 at cycle 2 and stays set.
// - 4-flit packet back-to-back, tail on flit 4, NUM_PIPELINE=1 -> in_packet=1 cycles 1..3, 0 at 4; flit_count=4, packet_count=1 by cycle 6.
// - credit_in pulse with credit_avail=CREDIT_DEPTH -> err_overflow=1 after credit_out; credit_avail unchanged.
// - CNT_WIDTH=4, 20 single-flit packets -> flit_count=packet_count=4'hF; stat_clear coincident with a send -> both 0.
// - rst asserted with flits in all stages (NUM_PIPELINE=3) -> send_out=0 next cycle onward, credit_avail=CREDIT_DEPTH, counters/errors 0.

Source files
------------

// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the credit-based NoC pipeline link.
// flit_t is the default flit layout; the link top re-declares it locally for non-default widths.
package noc_link_pkg;

    localparam int MAX_PIPELINE = 8;
    localparam int FLIT_W       = 32;
    localparam int DEST_W       = 6;

    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              is_tail;
    } flit_t;

    // Increment that sticks at the all-ones value of a width-bit counter (width <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/noc_link_stage.sv
// One retiming stage of the link: forward flit register plus reverse credit register.
// Only the valid bits are reset; the payload is don't-care while send is low.
module noc_link_stage
    import noc_link_pkg::*;
#(
    parameter type flit_type = flit_t
) (
    input  logic     clk,
    input  logic     rst,
    input  flit_type flit_d,
    input  logic     send_d,
    input  logic     credit_d,
    output flit_type flit_q,
    output logic     send_q,
    output logic     credit_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            send_q   <= 1'b0;
            credit_q <= 1'b0;
        end else begin
            send_q   <= send_d;
            credit_q <= credit_d;
        end
    end

    always_ff @(posedge clk) begin
        flit_q <= flit_d;
    end

endmodule

// File: rtl/noc_pipeline_link.sv
// Router-to-router link: NUM_PIPELINE retiming stages in each direction plus an
// in-line protocol monitor (shadow credits, packet framing, statistics, sticky errors).
module noc_pipeline_link
    import noc_link_pkg::*;
#(
    parameter int FLIT_WIDTH   = 32,
    parameter int DEST_WIDTH   = 6,
    parameter int NUM_PIPELINE = 0,
    parameter int CREDIT_DEPTH = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FLIT_WIDTH-1:0]             data_in,
    input  logic [DEST_WIDTH-1:0]             dest_in,
    input  logic                              is_tail_in,
    input  logic                              send_in,
    output logic                              credit_out,
    output logic [FLIT_WIDTH-1:0]             data_out,
    output logic [DEST_WIDTH-1:0]             dest_out,
    output logic                              is_tail_out,
    output logic                              send_out,
    input  logic                              credit_in,
    input  logic                              stat_clear,
    output logic [CNT_WIDTH-1:0]              flit_count,
    output logic [CNT_WIDTH-1:0]              packet_count,
    output logic [$clog2(CREDIT_DEPTH+1)-1:0] credit_avail,
    output logic                              in_packet,
    output logic                              err_underflow,
    output logic                              err_overflow
);

    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } link_flit_t;

    // Index 0 is the link entry for each direction; index NUM_PIPELINE is the exit.
    link_flit_t flit_chain   [NUM_PIPELINE+1];
    logic       send_chain   [NUM_PIPELINE+1];
    logic       credit_chain [NUM_PIPELINE+1];

    assign flit_chain[0]   = '{data: data_in, dest: dest_in, is_tail: is_tail_in};
    assign send_chain[0]   = send_in;
    assign credit_chain[0] = credit_in;

    for (genvar i = 0; i < NUM_PIPELINE; i++) begin : g_stage
        noc_link_stage #(
            .flit_type (link_flit_t)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flit_d   (flit_chain[i]),
            .send_d   (send_chain[i]),
            .credit_d (credit_chain[i]),
            .flit_q   (flit_chain[i+1]),
            .send_q   (send_chain[i+1]),
            .credit_q (credit_chain[i+1])
        );
    end

    assign data_out    = flit_chain[NUM_PIPELINE].data;
    assign dest_out    = flit_chain[NUM_PIPELINE].dest;
    assign is_tail_out = flit_chain[NUM_PIPELINE].is_tail;
    assign send_out    = send_chain[NUM_PIPELINE];
    assign credit_out  = credit_chain[NUM_PIPELINE];

    // Shadow of the upstream credit counter; a simultaneous send and credit return cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_avail  <= CW'(CREDIT_DEPTH);
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            in_packet     <= 1'b0;
        end else begin
            if (send_in && !credit_out) begin
                if (credit_avail == '0) begin
                    err_underflow <= 1'b1;
                end else begin
                    credit_avail <= credit_avail - CW'(1);
                end
            end else if (credit_out && !send_in) begin
                if (credit_avail == CW'(CREDIT_DEPTH)) begin
                    err_overflow <= 1'b1;
                end else begin
                    credit_avail <= credit_avail + CW'(1);
                end
            end
            if (send_in) begin
                in_packet <= ~is_tail_in;
            end
        end
    end

    // Delivery statistics on the downstream side; a clear request beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            flit_count   <= '0;
            packet_count <= '0;
        end else begin
            if (send_out) begin
                flit_count <= CNT_WIDTH'(sat_inc(64'(flit_count), CNT_WIDTH));
            end
            if (send_out && is_tail_out) begin
                packet_count <= CNT_WIDTH'(sat_inc(64'(packet_count), CNT_WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_noc_pipeline_link.sv
// Self-checking bench for noc_pipeline_link: a 2-stage link (dut_a) and a pass-through link (dut_z)
// share one stimulus stream; dut_a's forward and credit paths are tracked by a latency scoreboard.
module tb_noc_pipeline_link;

    localparam int A_NP = 2;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  dest;
        logic        tail;
        int          cyc;
    } exp_flit_t;

    typedef struct {
        logic        send;
        logic        tail;
        logic        credit;
        logic [31:0] data;
        logic [5:0]  dest;
        int          exp_fc;
        int          exp_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = '0;
    logic [5:0]  dest_in = '0;
    logic        is_tail_in = 1'b0;
    logic        send_in = 1'b0;
    logic        credit_in = 1'b0;
    logic        stat_clear = 1'b0;

    logic        a_credit_out, a_is_tail_out, a_send_out, a_in_packet, a_err_underflow, a_err_overflow;
    logic [31:0] a_data_out;
    logic [5:0]  a_dest_out;
    logic [3:0]  a_flit_count, a_packet_count;
    logic [2:0]  a_credit_avail;

    logic        z_credit_out, z_is_tail_out, z_send_out, z_in_packet, z_err_underflow, z_err_overflow;
    logic [31:0] z_data_out;
    logic [5:0]  z_dest_out;
    logic [7:0]  z_flit_count, z_packet_count;
    logic [0:0]  z_credit_avail;

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    bit        sb_enable = 1'b0;
    exp_flit_t flit_q[$];
    int        credit_q[$];
    vec_t      vecs[7];

    noc_pipeline_link #(
        .FLIT_WIDTH(32), .DEST_WIDTH(6), .NUM_PIPELINE(A_NP), .CREDIT_DEPTH(4), .CNT_WIDTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
        .send_in(send_in), .credit_out(a_credit_out), .data_out(a_data_out), .dest_out(a_dest_out),
        .is_tail_out(a_is_tail_out), .send_out(a_send_out), .credit_in(credit_in),
        .stat_clear(stat_clear), .flit_count(a_flit_count), .packet_count(a_packet_count),
        .credit_avail(a_credit_avail), .in_packet(a_in_packet), .err_underflow(a_err_underflow),
        .err_overflow(a_err_overflow)
    );

    noc_pipeline_link #(
        .FLIT_WIDTH(32), .DEST_WIDTH(6), .NUM_PIPELINE(0), .CREDIT_DEPTH(1), .CNT_WIDTH(8)
    ) dut_z (
        .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
        .send_in(send_in), .credit_out(z_credit_out), .data_out(z_data_out), .dest_out(z_dest_out),
        .is_tail_out(z_is_tail_out), .send_out(z_send_out), .credit_in(credit_in),
        .stat_clear(stat_clear), .flit_count(z_flit_count), .packet_count(z_packet_count),
        .credit_avail(z_credit_avail), .in_packet(z_in_packet), .err_underflow(z_err_underflow),
        .err_overflow(z_err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of inputs just after the edge, record expectations, return at the falling edge.
    task automatic applyStimulus(input logic s, input logic t, input logic c, input logic sc,
                                 input logic [31:0] d, input logic [5:0] de);
        @(posedge clk);
        #1;
        send_in    = s;
        is_tail_in = t;
        credit_in  = c;
        stat_clear = sc;
        data_in    = d;
        dest_in    = de;
        if (sb_enable && s) flit_q.push_back('{d, de, t, cyc + A_NP});
        if (sb_enable && c) credit_q.push_back(cyc + A_NP);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
    endtask

    task automatic doReset();
        checkOutput("sb_flit_drained", 64'(flit_q.size()), 64'd0);
        checkOutput("sb_credit_drained", 64'(credit_q.size()), 64'd0);
        sb_enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_in = 1'b0; credit_in = 1'b0; stat_clear = 1'b0; is_tail_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flit_q.delete();
        credit_q.delete();
        sb_enable = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard: every flit/credit leaving dut_a must match the oldest expectation in the same cycle.
    always @(negedge clk) begin
        if (!rst && sb_enable) begin
            if (flit_q.size() > 0 && flit_q[0].cyc < cyc) begin
                checkOutput("flit_missed", 64'(cyc), 64'(flit_q[0].cyc));
                void'(flit_q.pop_front());
            end
            if (a_send_out) begin
                if (flit_q.size() == 0) begin
                    checkOutput("flit_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_flit_t e;
                    e = flit_q.pop_front();
                    checkOutput("flit_cycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("flit_data", 64'(a_data_out), 64'(e.data));
                    checkOutput("flit_dest", 64'(a_dest_out), 64'(e.dest));
                    checkOutput("flit_tail", 64'(a_is_tail_out), 64'(e.tail));
                end
            end
            if (credit_q.size() > 0 && credit_q[0] < cyc) begin
                checkOutput("credit_missed", 64'(cyc), 64'(credit_q[0]));
                void'(credit_q.pop_front());
            end
            if (a_credit_out) begin
                if (credit_q.size() == 0) begin
                    checkOutput("credit_unexpected", 64'd1, 64'd0);
                end else begin
                    int ec;
                    ec = credit_q.pop_front();
                    checkOutput("credit_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // send, tail, credit, data, dest, expected z flit/packet counts visible in that cycle
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 6'h05, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 6'h00, 1, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, 6'h2A, 1, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 6'h3F, 2, 1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'h00, 3, 2};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0F0F_F0F0, 6'h11, 3, 2};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'h00, 4, 2};

        doReset();
        checkOutput("rst_a_send_out", 64'(a_send_out), 64'd0);
        checkOutput("rst_a_credit_out", 64'(a_credit_out), 64'd0);
        checkOutput("rst_a_flit_count", 64'(a_flit_count), 64'd0);
        checkOutput("rst_a_packet_count", 64'(a_packet_count), 64'd0);
        checkOutput("rst_a_credit_avail", 64'(a_credit_avail), 64'd4);
        checkOutput("rst_z_credit_avail", 64'(z_credit_avail), 64'd1);
        checkOutput("rst_a_in_packet", 64'(a_in_packet), 64'd0);
        checkOutput("rst_a_err_underflow", 64'(a_err_underflow), 64'd0);
        checkOutput("rst_a_err_overflow", 64'(a_err_overflow), 64'd0);

        // Pass-through link mirrors inputs combinationally; dut_a is covered by the scoreboard.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].send, vecs[i].tail, vecs[i].credit, 1'b0, vecs[i].data, vecs[i].dest);
            checkOutput("z_send_out", 64'(z_send_out), 64'(vecs[i].send));
            checkOutput("z_credit_out", 64'(z_credit_out), 64'(vecs[i].credit));
            if (vecs[i].send) begin
                checkOutput("z_data_out", 64'(z_data_out), 64'(vecs[i].data));
                checkOutput("z_dest_out", 64'(z_dest_out), 64'(vecs[i].dest));
                checkOutput("z_tail_out", 64'(z_is_tail_out), 64'(vecs[i].tail));
            end
            checkOutput("z_flit_count", 64'(z_flit_count), 64'(vecs[i].exp_fc));
            checkOutput("z_packet_count", 64'(z_packet_count), 64'(vecs[i].exp_pc));
        end
        idle(3);

        // Credit underflow on the depth-1 link; a send paired with a returning credit is harmless.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 6'h1);
        checkOutput("uf_avail_c0", 64'(z_credit_avail), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h2, 6'h2);
        checkOutput("uf_avail_c1", 64'(z_credit_avail), 64'd0);
        checkOutput("uf_err_c1", 64'(z_err_underflow), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h3, 6'h3);
        checkOutput("uf_avail_c2", 64'(z_credit_avail), 64'd0);
        checkOutput("uf_err_c2", 64'(z_err_underflow), 64'd0);
        idle(1);
        checkOutput("uf_err_c3", 64'(z_err_underflow), 64'd1);
        checkOutput("uf_avail_c3", 64'(z_credit_avail), 64'd0);
        checkOutput("uf_no_overflow", 64'(z_err_overflow), 64'd0);
        idle(1);
        checkOutput("uf_err_sticky", 64'(z_err_underflow), 64'd1);
        idle(1);

        // Credit overflow: a credit returned while the shadow counter is already full.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'h0);
        checkOutput("of_z_credit_out", 64'(z_credit_out), 64'd1);
        idle(1);
        checkOutput("of_z_err", 64'(z_err_overflow), 64'd1);
        checkOutput("of_z_avail", 64'(z_credit_avail), 64'd1);
        idle(1);
        checkOutput("of_a_err_c2", 64'(a_err_overflow), 64'd0);
        idle(1);
        checkOutput("of_a_err_c3", 64'(a_err_overflow), 64'd1);
        checkOutput("of_a_avail", 64'(a_credit_avail), 64'd4);
        idle(1);
        checkOutput("of_a_err_sticky", 64'(a_err_overflow), 64'd1);

        // Four-flit packet followed by a single-flit packet.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 3), 1'b0, 1'b0, 32'h1000_0000 + 32'(i), 6'(i));
            checkOutput("fr_in_packet", 64'(a_in_packet), (i == 0) ? 64'd0 : 64'd1);
        end
        idle(1);
        checkOutput("fr_in_packet_end", 64'(a_in_packet), 64'd0);
        checkOutput("fr_z_flit_count", 64'(z_flit_count), 64'd4);
        idle(2);
        checkOutput("fr_a_flit_count", 64'(a_flit_count), 64'd4);
        checkOutput("fr_a_packet_count", 64'(a_packet_count), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000_0000, 6'h07);
        idle(1);
        checkOutput("fr_single_flit", 64'(a_in_packet), 64'd0);
        idle(2);

        // Saturation of the 4-bit counters, then a clear coinciding with deliveries.
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'(i), 6'(i));
        idle(3);
        checkOutput("sat_a_flit", 64'(a_flit_count), 64'hF);
        checkOutput("sat_a_packet", 64'(a_packet_count), 64'hF);
        checkOutput("sat_z_flit", 64'(z_flit_count), 64'd20);
        checkOutput("sat_z_packet", 64'(z_packet_count), 64'd20);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFE_0000, 6'h0A);
        idle(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 6'h0B);
        checkOutput("clr_a_send_coincident", 64'(a_send_out), 64'd1);
        idle(1);
        checkOutput("clr_a_flit", 64'(a_flit_count), 64'd0);
        checkOutput("clr_a_packet", 64'(a_packet_count), 64'd0);
        checkOutput("clr_z_flit", 64'(z_flit_count), 64'd0);
        checkOutput("clr_z_packet", 64'(z_packet_count), 64'd0);
        checkOutput("clr_keeps_err", 64'(a_err_underflow), 64'd1);
        checkOutput("clr_keeps_avail", 64'(a_credit_avail), 64'd0);
        idle(2);
        checkOutput("clr_a_flit_after", 64'(a_flit_count), 64'd1);
        checkOutput("clr_a_packet_after", 64'(a_packet_count), 64'd1);

        // Reset with every stage of dut_a holding a flit and a credit.
        checkOutput("sb_flit_drained", 64'(flit_q.size()), 64'd0);
        sb_enable = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h3000_0000 + 32'(i), 6'h15);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_in = 1'b0; credit_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mr_avail", 64'(a_credit_avail), 64'd4);
        checkOutput("mr_flit_count", 64'(a_flit_count), 64'd0);
        checkOutput("mr_err_underflow", 64'(a_err_underflow), 64'd0);
        checkOutput("mr_in_packet", 64'(a_in_packet), 64'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mr_send_out", 64'(a_send_out), 64'd0);
            checkOutput("mr_credit_out", 64'(a_credit_out), 64'd0);
            @(negedge clk);
        end
        sb_enable = 1'b1;
        idle(1);
        checkOutput("final_flit_q", 64'(flit_q.size()), 64'd0);
        checkOutput("final_credit_q", 64'(credit_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
